// File: rtl/light_seq_ctrl.sv
// light_seq_ctrl: dwell-timed colour sequencer with a one-deep memory fetch.
// Define LIGHT_SEQ_TIMEOUT_EN to enable the WAIT_MAX fetch timeout and fetch_err.
module light_seq_ctrl #(
   parameter int WAIT_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        button,
   input  logic        lightsSel,
   input  logic [5:0]  threshold,
   output logic        mem_req,
   output logic [2:0]  mem_addr,
   input  logic        mem_valid,
   input  logic [23:0] mem_data,
   output logic [23:0] lightsOut,
   output logic        busy,
   output logic        fetch_err
);

`ifdef LIGHT_SEQ_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
   assign fetch_err = 1'b0;
`endif

   localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t              state;
   logic [2:0]          colour;
   logic [5:0]          cnt;
   logic [23:0]         rgb_q;
   logic                dirty;
   logic                req_q;
   logic                busy_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                advance;
   logic                step;
   logic                timeout;

   assign advance = button && lightsSel;
   // >= rather than == so a threshold lowered below cnt steps at once
   assign step    = advance && (cnt >= threshold);

   assign timeout = TIMEOUT_EN && (state == WAIT) && !mem_valid &&
                    (wait_cnt == WAIT_W'(WAIT_MAX - 1));

   assign mem_req   = req_q;
   assign mem_addr  = colour;
   assign busy      = busy_q;
   assign lightsOut = lightsSel ? rgb_q : 24'hFFFFFF;

   // Dwell counter: steps colour 1..6 every threshold+1 enabled cycles
   always_ff @(posedge clk) begin
      if (rst_n) begin
         colour <= 3'd1;
         cnt    <= 6'd0;
      end else if (step) begin
         colour <= (colour == 3'd6) ? 3'd1 : colour + 3'd1;
         cnt    <= 6'd0;
      end else if (advance) begin
         cnt <= cnt + 6'd1;
      end
   end

   // Fetch FSM: one outstanding read; dirty re-arms it for the latest colour
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state    <= IDLE;
         dirty    <= 1'b1;
         rgb_q    <= 24'h000000;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         wait_cnt <= '0;
      end else begin
         req_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dirty) begin
                  state  <= REQ;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            REQ: begin
               dirty    <= 1'b0;
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (mem_valid) begin
                  rgb_q <= mem_data;
                  if (dirty) begin
                     state <= REQ;
                     req_q <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else if (timeout) begin
                  dirty  <= 1'b1;
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
         // a step in the same cycle as the REQ clear must win
         if (step) dirty <= 1'b1;
      end
   end

`ifdef LIGHT_SEQ_TIMEOUT_EN
   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst_n) fetch_err <= 1'b0;
      else if (timeout) fetch_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_light_seq_ctrl.sv
// tb_light_seq_ctrl: directed bench for light_seq_ctrl.
// Uses a 2-cycle colour memory model; timeout checks follow LIGHT_SEQ_TIMEOUT_EN.
module tb_light_seq_ctrl;

   localparam int WAIT_MAX = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        button    = 1'b0;
   logic        lightsSel = 1'b1;
   logic [5:0]  threshold = 6'd10;
   logic        mem_req;
   logic [2:0]  mem_addr;
   logic        mem_valid = 1'b0;
   logic [23:0] mem_data  = 24'h0;
   logic [23:0] lightsOut;
   logic        busy;
   logic        fetch_err;

   logic        mem_en   = 1'b1;
   logic        v1       = 1'b0;
   logic [2:0]  a1       = 3'd0;
   logic        bad_addr = 1'b0;
   int          req_cnt  = 0;
   int          n_checks = 0;
   int          n_pass   = 0;

   logic [23:0] seq2 [6] = '{24'h00FF00, 24'h00FFFF, 24'hFF0000,
                             24'hFF00FF, 24'hFFFF00, 24'h0000FF};

   always #5 clk = ~clk;

   light_seq_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .button    (button),
      .lightsSel (lightsSel),
      .threshold (threshold),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_valid (mem_valid),
      .mem_data  (mem_data),
      .lightsOut (lightsOut),
      .busy      (busy),
      .fetch_err (fetch_err)
   );

   function automatic logic [23:0] rom(input logic [2:0] a);
      case (a)
         3'd1:    return 24'h0000FF;
         3'd2:    return 24'h00FF00;
         3'd3:    return 24'h00FFFF;
         3'd4:    return 24'hFF0000;
         3'd5:    return 24'hFF00FF;
         3'd6:    return 24'hFFFF00;
         default: return 24'h000000;
      endcase
   endfunction

   // memory: valid two cycles after the request
   always @(posedge clk) begin
      v1        <= mem_req && mem_en;
      a1        <= mem_addr;
      mem_valid <= v1;
      mem_data  <= rom(a1);
   end

   always @(negedge clk) begin
      if (mem_req) req_cnt++;
      if (mem_addr == 3'd0 || mem_addr == 3'd7) bad_addr = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_change(input int limit, output int n);
      logic [23:0] prev;
      prev = lightsOut;
      n = 0;
      while (lightsOut === prev && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int   n;
      logic ok;

      // reset state and first fetch
      cyc(5);
      check("rst_lights", lightsOut, 24'h0);
      check("rst_req", mem_req, 0);
      check("rst_busy", busy, 0);
      check("rst_err", fetch_err, 0);
      check("rst_addr", mem_addr, 1);
      rst_n = 1'b0;
      cyc(1);
      check("first_req", mem_req, 1);
      check("first_busy", busy, 1);
      cyc(1);
      check("req_one_cycle", mem_req, 0);
      cyc(1);
      check("pre_fetch", lightsOut, 24'h0);
      cyc(1);
      check("entry1", lightsOut, 24'h0000FF);
      check("idle_after", busy, 0);
      ok = 1'b1;
      repeat (50) begin
         cyc(1);
         if (lightsOut !== 24'h0000FF) ok = 1'b0;
      end
      check("entry1_hold", ok, 1);

      // threshold 10: one step per 11 cycles
      button = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_change(40, n);
         check("t10_interval", n, (i == 0) ? 15 : 11);
         check("t10_rgb", lightsOut, seq2[i]);
      end

      // threshold 20 mid-run, then threshold 0
      threshold = 6'd20;
      wait_change(40, n);
      check("t20_interval", n, 21);
      check("t20_rgb", lightsOut, 24'h00FF00);
      wait_change(40, n);
      check("t20_interval2", n, 21);
      check("t20_rgb2", lightsOut, 24'h00FFFF);
      threshold = 6'd0;
      req_cnt = 0;
      cyc(20);
      button = 1'b0;
      check("t0_reqs_le_steps", req_cnt <= 20, 1);
      check("t0_reqs_seen", req_cnt > 0, 1);
      check("t0_addr", mem_addr, 5);
      cyc(15);
      check("t0_idle", busy, 0);
      check("t0_rgb", lightsOut, 24'hFF00FF);

      // release mid-dwell freezes cnt and colour
      threshold = 6'd10;
      button = 1'b1;
      cyc(6);
      button = 1'b0;
      ok = 1'b1;
      req_cnt = 0;
      repeat (30) begin
         cyc(1);
         if (lightsOut !== 24'hFF00FF || mem_addr !== 3'd5) ok = 1'b0;
      end
      check("hold_frozen", ok, 1);
      check("hold_noreq", req_cnt, 0);
      button = 1'b1;
      cyc(4);
      check("resume_wait", mem_addr, 5);
      cyc(1);
      check("resume_step", mem_addr, 6);
      cyc(3);
      check("resume_old", lightsOut, 24'hFF00FF);
      cyc(1);
      check("resume_new", lightsOut, 24'hFFFF00);
      button = 1'b0;

      // lightsSel=0 forces white and freezes; reset interplay
      button = 1'b1;
      lightsSel = 1'b0;
      #1;
      check("sel0_white", lightsOut, 24'hFFFFFF);
      ok = 1'b1;
      repeat (20) begin
         cyc(1);
         if (mem_addr !== 3'd6 || lightsOut !== 24'hFFFFFF) ok = 1'b0;
      end
      check("sel0_frozen", ok, 1);
      rst_n = 1'b1;
      cyc(1);
      check("rst_white", lightsOut, 24'hFFFFFF);
      check("rst_colour", mem_addr, 1);
      lightsSel = 1'b1;
      #1;
      check("rst_sel1", lightsOut, 24'h0);
      button = 1'b0;
      cyc(2);
      rst_n = 1'b0;
      cyc(3);
      check("rel_pre", lightsOut, 24'h0);
      cyc(1);
      check("rel_entry1", lightsOut, 24'h0000FF);

      // suppressed mem_valid
      mem_en = 1'b0;
      threshold = 6'd0;
      button = 1'b1;
      cyc(1);
      button = 1'b0;
      check("stall_addr", mem_addr, 2);
`ifdef LIGHT_SEQ_TIMEOUT_EN
      cyc(WAIT_MAX + 1);
      check("to_before", fetch_err, 0);
      check("to_busy", busy, 1);
      cyc(1);
      check("to_err", fetch_err, 1);
      check("to_idle", busy, 0);
      cyc(1);
      check("to_retry", mem_req, 1);
      mem_en = 1'b1;
      cyc(10);
      check("to_recover", lightsOut, 24'h00FF00);
      check("to_sticky", fetch_err, 1);
`else
      cyc(30);
      check("stall_busy", busy, 1);
      check("stall_err", fetch_err, 0);
      check("stall_rgb", lightsOut, 24'h0000FF);
`endif
      check("addr_range", bad_addr, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
